spi_reg_rd_mux: RTL and testbench

- Parametrised read-back multiplexer for the SPI peripheral register file.
- Generalises the 2:1 control/data output select to N_REGS registers.
- Adds a registered read path with request/valid handshake, out-of-range detection, and an internal sticky status register (clear-on-read) that drives an interrupt.
- Sits between the SPI register bank and the processor load-data path.

---
 rtl/spi_pkg.sv | 33 +++
 rtl/spi_reg_rd_mux_if.sv | 30 +++
 rtl/spi_sticky_flags.sv | 37 +++
 rtl/spi_reg_rd_mux.sv | 97 +++++++++
 tb/tb_spi_reg_rd_mux.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI register read-back path: slot map, event bits,
// and a small range-check helper.
package spi_pkg;

  localparam int SPI_DATA_W = 32;

  localparam int REG_CTRL   = 0;
  localparam int REG_DATOS  = 1;
  localparam int REG_STATUS = 2;
  localparam int REG_FREE   = 3;

  localparam int EVT_TX_DONE = 0;
  localparam int EVT_RX_FULL = 1;
  localparam int EVT_OVERRUN = 2;

  typedef enum logic [1:0] {
    RD_SLOT   = 2'd0,
    RD_STATUS = 2'd1,
    RD_ERR    = 2'd2
  } rd_kind_e;

  function automatic rd_kind_e classify_sel(input int sel, input int n_regs,
                                            input int status_idx);
    if (sel >= n_regs) begin
      return RD_ERR;
    end
    if (sel == status_idx) begin
      return RD_STATUS;
    end
    return RD_SLOT;
  endfunction

endpackage

// File: rtl/spi_reg_rd_mux_if.sv
// Read request/response bundle between the processor load path (master)
// and the register read-back mux (slave).
interface spi_reg_rd_mux_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 2
);

  logic              rd_req_i;
  logic [SEL_W-1:0]  reg_sel_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rvalid_o;
  logic              sel_err_o;

  modport master (
    output rd_req_i,
    output reg_sel_i,
    input  rdata_o,
    input  rvalid_o,
    input  sel_err_o
  );

  modport slave (
    input  rd_req_i,
    input  reg_sel_i,
    output rdata_o,
    output rvalid_o,
    output sel_err_o
  );

endinterface

// File: rtl/spi_sticky_flags.sv
// Sticky event flags with clear-on-read (set beats clear) and a registered,
// masked interrupt reduction.
module spi_sticky_flags #(
  parameter int EVT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [EVT_W-1:0] set_i,
  input  logic             clr_i,
  input  logic [EVT_W-1:0] mask_i,
  output logic [EVT_W-1:0] flags_o,
  output logic             irq_o
);

  logic [EVT_W-1:0] flags_q, flags_d;
  logic             irq_q, irq_d;

  // An event arriving on the clearing edge survives the clear.
  always_comb begin
    flags_d = clr_i ? set_i : (flags_q | set_i);
    irq_d   = |(flags_q & mask_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      irq_q   <= irq_d;
    end
  end

  assign flags_o = flags_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/spi_reg_rd_mux.sv
// Registered N-way read-back mux for the SPI register file, with one slot
// replaced by the internal clear-on-read sticky status register.
module spi_reg_rd_mux
  import spi_pkg::*;
#(
  parameter int DATA_W     = SPI_DATA_W,
  parameter int N_REGS     = 4,
  parameter int EVT_W      = 8,
  parameter int STATUS_IDX = REG_STATUS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REGS*DATA_W-1:0] reg_in_i,
  input  logic [EVT_W-1:0]         evt_i,
  input  logic [EVT_W-1:0]         irq_mask_i,
  spi_reg_rd_mux_if.slave          rd_if,
  output logic                     irq_o
);

  localparam int SEL_W = $clog2(N_REGS);

  logic [DATA_W-1:0] slot_w [N_REGS];
  logic [EVT_W-1:0]  flags_w;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              sel_err_q, sel_err_d;
  logic              status_rd;
  rd_kind_e          kind;
  logic [SEL_W-1:0]  sel;

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_slot
      assign slot_w[gi] = reg_in_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign sel  = rd_if.reg_sel_i;
  assign kind = classify_sel(int'(sel), N_REGS, STATUS_IDX);

  always_comb begin
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    sel_err_d = 1'b0;
    status_rd = 1'b0;
    if (rd_if.rd_req_i) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      case (kind)
        RD_ERR: begin
          sel_err_d = 1'b1;
        end
        RD_STATUS: begin
          rdata_d   = DATA_W'(flags_w);
          status_rd = 1'b1;
        end
        default: begin
          for (int k = 0; k < N_REGS; k++) begin
            if (int'(sel) == k) begin
              rdata_d = slot_w[k];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      sel_err_q <= sel_err_d;
    end
  end

  spi_sticky_flags #(
    .EVT_W(EVT_W)
  ) u_sticky (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .set_i  (evt_i),
    .clr_i  (status_rd),
    .mask_i (irq_mask_i),
    .flags_o(flags_w),
    .irq_o  (irq_o)
  );

  assign rd_if.rdata_o   = rdata_q;
  assign rd_if.rvalid_o  = rvalid_q;
  assign rd_if.sel_err_o = sel_err_q;

endmodule

// File: tb/tb_spi_reg_rd_mux.sv
// Directed vector bench for spi_reg_rd_mux built with N_REGS=3 so that
// index 3 is out of range and index 2 is the sticky status slot.
module tb_spi_reg_rd_mux;

  localparam int DATA_W = 32;
  localparam int N_REGS = 3;
  localparam int SEL_W  = 2;
  localparam int EVT_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N_REGS*DATA_W-1:0] reg_in;
  logic [EVT_W-1:0]         evt;
  logic [EVT_W-1:0]         mask;
  logic                     irq;

  int total = 0;
  int bad   = 0;

  spi_reg_rd_mux_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) rd_if ();

  spi_reg_rd_mux #(
    .DATA_W    (DATA_W),
    .N_REGS    (N_REGS),
    .EVT_W     (EVT_W),
    .STATUS_IDX(2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .reg_in_i  (reg_in),
    .evt_i     (evt),
    .irq_mask_i(mask),
    .rd_if     (rd_if.slave),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              req;
    logic [SEL_W-1:0]  sel;
    logic [EVT_W-1:0]  evt;
    logic [EVT_W-1:0]  mask;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_rvalid;
    logic              exp_err;
    logic              exp_irq;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic req, input logic [SEL_W-1:0] s,
                       input logic [EVT_W-1:0] e, input logic [EVT_W-1:0] m);
    @(negedge clk);
    rst             = r;
    rd_if.rd_req_i  = req;
    rd_if.reg_sel_i = s;
    evt             = e;
    mask            = m;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [DATA_W-1:0] rd,
                         input logic v, input logic er, input logic iq);
    chk({tag, ".rdata"},   rd_if.rdata_o, rd);
    chk({tag, ".rvalid"},  DATA_W'(rd_if.rvalid_o), DATA_W'(v));
    chk({tag, ".sel_err"}, DATA_W'(rd_if.sel_err_o), DATA_W'(er));
    chk({tag, ".irq"},     DATA_W'(irq), DATA_W'(iq));
    $display("txn %s rdata=%h rvalid=%0b sel_err=%0b irq=%0b",
             tag, rd_if.rdata_o, rd_if.rvalid_o, rd_if.sel_err_o, irq);
  endtask

  initial begin
    //          req  sel   evt    mask   rdata          v     err   irq
    vecs[0]  = '{1'b1, 2'd0, 8'h00, 8'h04, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 8'h00, 8'h04, 32'h0000_00A5, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 8'h04, 8'h04, 32'h0000_00A5, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 8'h00, 8'h04, 32'h0000_00A5, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 2'd2, 8'h00, 8'h04, 32'h0000_0004, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 8'h04, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'd2, 8'h00, 8'h04, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 8'h01, 8'h04, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'd2, 8'h00, 8'h04, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 2'd3, 8'h00, 8'h04, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 2'd0, 8'h00, 8'h04, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 8'h02, 8'h02, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 8'h00, 8'h02, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 8'h00, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 8'h00, 8'h02, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 2'd2, 8'h00, 8'h02, 32'h0000_0002, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 2'd0, 8'h00, 8'h02, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 2'd1, 8'h05, 8'h05, 32'h0000_00A5, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 2'd2, 8'h00, 8'h05, 32'h0000_0005, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 2'd0, 8'h00, 8'h05, 32'h0000_0005, 1'b0, 1'b0, 1'b0};

    reg_in          = {32'hDEAD_BEEF, 32'h0000_00A5, 32'hCAFE_0001};
    rst             = 1'b1;
    rd_if.rd_req_i  = 1'b0;
    rd_if.reg_sel_i = '0;
    evt             = '0;
    mask            = '0;

    drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
      chk_all($sformatf("idle%0d", i), 32'h0, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      drive(1'b0, vecs[i].req, vecs[i].sel, vecs[i].evt, vecs[i].mask);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_rvalid,
              vecs[i].exp_err, vecs[i].exp_irq);
    end

    // Reset landing on the edge that samples a read, with a sticky bit set.
    drive(1'b0, 1'b0, 2'd0, 8'h08, 8'h08);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h08);
    chk_all("pre_rst", 32'h5, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 8'h08);
    chk_all("rst_read", 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h08);
    chk_all("post_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd2, 8'h00, 8'h08);
    chk_all("post_rst_status", 32'h0, 1'b1, 1'b0, 1'b0);

    // Request followed by reset: pulse appears once, then reset wipes it.
    drive(1'b0, 1'b1, 2'd1, 8'h00, 8'h00);
    chk_all("req_b4_rst", 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    chk_all("rst_after_req", 32'h0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
